// File: rtl/crc_mem_writer.sv
// crc_mem_writer: packet writer for the CRC packet memory.
// Accepts a 32-bit word stream and writes each word into a circular buffer.
// Computes the Ethernet CRC-32, appends the FCS word after the last data word
// and pulses a packet descriptor. Packets that are aborted or too long are
// rewound out of the buffer and reported on pkt_err.
// Optional feature macro: CRC_STATS_EN adds saturating packet/error counters.
module crc_mem_writer #(
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 10,
    parameter int MAX_PKT_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [1:0]        in_bytes,
    input  logic [AWIDTH-1:0] free_ptr,
    output logic [AWIDTH-1:0] f0_waddr,
    output logic [DWIDTH-1:0] f0_wdata,
    output logic              f0_write,
    output logic              pkt_done,
    output logic [AWIDTH-1:0] pkt_base,
    output logic [AWIDTH-1:0] pkt_words,
    output logic [1:0]        pkt_last_bytes,
    output logic [31:0]       pkt_fcs,
    output logic              pkt_err
`ifdef CRC_STATS_EN
    ,
    output logic [15:0]       stat_pkts,
    output logic [15:0]       stat_errs
`endif
);

    localparam int          CWIDTH   = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        FCS  = 2'd2
    } state_t;

    // Reflected CRC-32 over the first nbytes bytes of a word, byte0 first, LSB first.
    function automatic logic [31:0] crc_word(input logic [31:0] crc_in,
                                             input logic [31:0] data,
                                             input logic [2:0]  nbytes);
        logic [31:0] c;
        c = crc_in;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(nbytes)) begin
                c = c ^ {24'd0, data[8*k +: 8]};
                for (int b = 0; b < 8; b++) begin
                    c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   wptr_q, wptr_d;
    logic [AWIDTH-1:0]   base_q, base_d;
    logic [31:0]         crc_q, crc_d;
    logic [CWIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]          lb_q, lb_d;

    logic                f0_write_q, f0_write_d;
    logic [AWIDTH-1:0]   f0_waddr_q, f0_waddr_d;
    logic [DWIDTH-1:0]   f0_wdata_q, f0_wdata_d;
    logic                pkt_done_q, pkt_done_d;
    logic [AWIDTH-1:0]   pkt_base_q, pkt_base_d;
    logic [AWIDTH-1:0]   pkt_words_q, pkt_words_d;
    logic [1:0]          pkt_last_bytes_q, pkt_last_bytes_d;
    logic [31:0]         pkt_fcs_q, pkt_fcs_d;
    logic                pkt_err_q, pkt_err_d;

    logic [AWIDTH-1:0]   free;
    logic                ready;
    logic                accept;
    logic [2:0]          word_bytes;
    logic [AWIDTH-1:0]   start_addr;

    // Free space always keeps one slot back for the FCS word; no input during FCS.
    always_comb begin
        free  = free_ptr - wptr_q - AWIDTH'(1);
        ready = (state_q != FCS) && (free >= AWIDTH'(2));
    end

    assign in_ready = ready;

    // Next-state, write-port and descriptor logic.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d          = state_q;
        wptr_d           = wptr_q;
        base_d           = base_q;
        crc_d            = crc_q;
        cnt_d            = cnt_q;
        lb_d             = lb_q;
        f0_write_d       = 1'b0;
        f0_waddr_d       = f0_waddr_q;
        f0_wdata_d       = f0_wdata_q;
        pkt_done_d       = 1'b0;
        pkt_base_d       = pkt_base_q;
        pkt_words_d      = pkt_words_q;
        pkt_last_bytes_d = pkt_last_bytes_q;
        pkt_fcs_d        = pkt_fcs_q;
        pkt_err_d        = 1'b0;

        accept     = in_valid && ready;
        word_bytes = (in_eop && (in_bytes != 2'd0)) ? {1'b0, in_bytes} : 3'd4;
        // A sop inside a packet restarts at the abandoned packet's base.
        start_addr = (state_q == DATA) ? base_q : wptr_q;

        case (state_q)
            IDLE, DATA: begin
                if (accept) begin
                    if (in_sop) begin
                        pkt_err_d  = (state_q == DATA);
                        base_d     = start_addr;
                        f0_write_d = 1'b1;
                        f0_waddr_d = start_addr;
                        f0_wdata_d = in_data;
                        wptr_d     = start_addr + AWIDTH'(1);
                        crc_d      = crc_word(CRC_INIT, in_data, word_bytes);
                        cnt_d      = CWIDTH'(1);
                        lb_d       = in_bytes;
                        state_d    = in_eop ? FCS : DATA;
                    end else if (state_q == DATA) begin
                        if (cnt_q == CWIDTH'(MAX_PKT_WORDS)) begin
                            // Oversized packet: drop this word and rewind the whole packet.
                            pkt_err_d = 1'b1;
                            wptr_d    = base_q;
                            crc_d     = CRC_INIT;
                            cnt_d     = '0;
                            state_d   = IDLE;
                        end else begin
                            f0_write_d = 1'b1;
                            f0_waddr_d = wptr_q;
                            f0_wdata_d = in_data;
                            wptr_d     = wptr_q + AWIDTH'(1);
                            crc_d      = crc_word(crc_q, in_data, word_bytes);
                            cnt_d      = cnt_q + CWIDTH'(1);
                            lb_d       = in_bytes;
                            if (in_eop) begin
                                state_d = FCS;
                            end
                        end
                    end
                    // A word without sop in IDLE is silently dropped.
                end
            end

            FCS: begin
                f0_write_d       = 1'b1;
                f0_waddr_d       = wptr_q;
                f0_wdata_d       = ~crc_q;
                wptr_d           = wptr_q + AWIDTH'(1);
                pkt_done_d       = 1'b1;
                pkt_base_d       = base_q;
                pkt_words_d      = AWIDTH'(cnt_q);
                pkt_last_bytes_d = lb_q;
                pkt_fcs_d        = ~crc_q;
                crc_d            = CRC_INIT;
                cnt_d            = '0;
                state_d          = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q          <= IDLE;
            wptr_q           <= '0;
            base_q           <= '0;
            crc_q            <= CRC_INIT;
            cnt_q            <= '0;
            lb_q             <= '0;
            f0_write_q       <= 1'b0;
            f0_waddr_q       <= '0;
            f0_wdata_q       <= '0;
            pkt_done_q       <= 1'b0;
            pkt_base_q       <= '0;
            pkt_words_q      <= '0;
            pkt_last_bytes_q <= '0;
            pkt_fcs_q        <= '0;
            pkt_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            wptr_q           <= wptr_d;
            base_q           <= base_d;
            crc_q            <= crc_d;
            cnt_q            <= cnt_d;
            lb_q             <= lb_d;
            f0_write_q       <= f0_write_d;
            f0_waddr_q       <= f0_waddr_d;
            f0_wdata_q       <= f0_wdata_d;
            pkt_done_q       <= pkt_done_d;
            pkt_base_q       <= pkt_base_d;
            pkt_words_q      <= pkt_words_d;
            pkt_last_bytes_q <= pkt_last_bytes_d;
            pkt_fcs_q        <= pkt_fcs_d;
            pkt_err_q        <= pkt_err_d;
        end
    end

    assign f0_write       = f0_write_q;
    assign f0_waddr       = f0_waddr_q;
    assign f0_wdata       = f0_wdata_q;
    assign pkt_done       = pkt_done_q;
    assign pkt_base       = pkt_base_q;
    assign pkt_words      = pkt_words_q;
    assign pkt_last_bytes = pkt_last_bytes_q;
    assign pkt_fcs        = pkt_fcs_q;
    assign pkt_err        = pkt_err_q;

`ifdef CRC_STATS_EN
    logic [15:0] stat_pkts_q, stat_pkts_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    // Saturating counters, stepped together with the pulses they count.
    always_comb begin
        stat_pkts_d = stat_pkts_q;
        stat_errs_d = stat_errs_q;
        if (pkt_done_d && (stat_pkts_q != 16'hFFFF)) begin
            stat_pkts_d = stat_pkts_q + 16'd1;
        end
        if (pkt_err_d && (stat_errs_q != 16'hFFFF)) begin
            stat_errs_d = stat_errs_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts_q <= '0;
            stat_errs_q <= '0;
        end else begin
            stat_pkts_q <= stat_pkts_d;
            stat_errs_q <= stat_errs_d;
        end
    end

    assign stat_pkts = stat_pkts_q;
    assign stat_errs = stat_errs_q;
`endif

endmodule
